// File: rtl/jtframe_psg_pkg.sv
// Shared types and constants for the PSG channel mixer: FSM states, unity gain, output bounds.
package jtframe_psg_pkg;

   typedef enum logic [2:0] {IDLE, MAC, DCRM, LPF, OUT} state_t;

   localparam logic [7:0]        GAIN_UNITY = 8'h10;
   localparam logic signed [15:0] SAT_MAX   = 16'sh7FFF;
   localparam logic signed [15:0] SAT_MIN   = 16'sh8000;

endpackage

// File: rtl/jtframe_psg_dcblk.sv
// DC tracker: removes the running average from the unsigned mix. The first sample after
// reset preloads the average so the output starts at zero instead of popping.
module jtframe_psg_dcblk #(
   parameter int MW   = 16,
   parameter int DCSH = 9
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [MW-1:0]        x_in,
   output logic signed [MW:0]   x_out
);

   // avg carries DCSH fractional bits, so adding x here is avg += x / 2^DCSH
   logic signed [MW+DCSH:0] avg;
   logic signed [MW+DCSH:0] avg_base;
   logic signed [MW:0]      mix_s;
   logic signed [MW:0]      avg_i;
   logic signed [MW:0]      x;
   logic                    first;

   always_comb begin
      mix_s    = signed'({1'b0, x_in});
      avg_base = first ? ((MW+DCSH+1)'(mix_s) <<< DCSH) : avg;
      avg_i    = avg_base[MW+DCSH:DCSH];
      x        = mix_s - avg_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         avg   <= '0;
         first <= 1'b1;
         x_out <= '0;
      end else if (en) begin
         avg   <= avg_base + (MW+DCSH+1)'(x);
         first <= 1'b0;
         x_out <= x;
      end
   end

endmodule

// File: rtl/jtframe_psg_mixer.sv
// CH-channel PSG mixer: shared MAC over snapshotted channels, DC removal, scale and saturate.
// Define JTFRAME_PSG_LPF_EN to insert a first-order low-pass stage (one extra cycle latency).
//
// state | meaning
// IDLE  | waiting for sample; snapshot inputs on accept
// MAC   | acc += din_s[k] * gain_s[k], one channel per cycle
// DCRM  | DC tracker update on acc>>4
// LPF   | z += (x - z)>>>2 (only with JTFRAME_PSG_LPF_EN)
// OUT   | scale, saturate, register dout and pulse dout_stb
module jtframe_psg_mixer
   import jtframe_psg_pkg::*;
#(
   parameter int CH    = 3,
   parameter int DW    = 10,
   parameter int DCSH  = 9,
   parameter int OUTSH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CH*DW-1:0]     din,
   input  logic [CH*8-1:0]      gain,
   input  logic                 sample,
   output logic [15:0]          dout,
   output logic                 dout_stb,
   output logic                 busy,
   output logic                 overrun
);

   localparam int CW  = $clog2(CH);
   localparam int KW  = (CW > 0) ? CW : 1;
   localparam int AW  = DW + 8 + CW;
   localparam int MW  = DW + 4 + CW;
   localparam int YW0 = MW + 1 + OUTSH;
   localparam int YW  = (YW0 > 17) ? YW0 : 17;

   state_t              state;
   logic [CH*DW-1:0]    din_s;
   logic [CH*8-1:0]     gain_s;
   logic [AW-1:0]       acc;
   logic [KW-1:0]       k;
   logic [DW+7:0]       prod;
   logic [MW-1:0]       mix;
   logic signed [MW:0]  x_dc;
   logic signed [MW:0]  x_sel;
   logic signed [YW-1:0] y;
   logic signed [15:0]  y_sat;

   always_comb begin
      prod = din_s[int'(k)*DW +: DW] * gain_s[int'(k)*8 +: 8];
      mix  = acc[AW-1:4];
   end

   jtframe_psg_dcblk #(
      .MW   (MW),
      .DCSH (DCSH)
   ) u_dcblk (
      .clk   (clk),
      .rst   (rst),
      .en    (state == DCRM),
      .x_in  (mix),
      .x_out (x_dc)
   );

`ifdef JTFRAME_PSG_LPF_EN
   logic signed [MW:0]   z;
   logic signed [MW+1:0] dz;

   always_comb dz = (MW+2)'(x_dc) - (MW+2)'(z);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)               z <= '0;
      else if (state == LPF) z <= z + (MW+1)'(dz >>> 2);
   end

   assign x_sel = z;
`else
   assign x_sel = x_dc;
`endif

   always_comb begin
      y = YW'(x_sel) <<< OUTSH;
      if (y > YW'(SAT_MAX))      y_sat = SAT_MAX;
      else if (y < YW'(SAT_MIN)) y_sat = SAT_MIN;
      else                       y_sat = y[15:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         din_s    <= '0;
         gain_s   <= '0;
         acc      <= '0;
         k        <= '0;
         busy     <= 1'b0;
         overrun  <= 1'b0;
         dout     <= '0;
         dout_stb <= 1'b0;
      end else begin
         dout_stb <= 1'b0;
         // any sample outside IDLE, including the OUT cycle, is dropped
         if (sample && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (sample) begin
               din_s  <= din;
               gain_s <= gain;
               acc    <= '0;
               k      <= '0;
               busy   <= 1'b1;
               state  <= MAC;
            end
            MAC: begin
               acc <= acc + AW'(prod);
               k   <= k + 1'b1;
               if (k == KW'(CH-1)) state <= DCRM;
            end
`ifdef JTFRAME_PSG_LPF_EN
            DCRM: state <= LPF;
            LPF:  state <= OUT;
`else
            DCRM: state <= OUT;
`endif
            OUT: begin
               dout     <= y_sat;
               dout_stb <= 1'b1;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
